pe_evolve_par: RTL and testbench

- Parametrised next-generation evolution processing element for the tree-walk sequence simulator.
- Accepts a parent packet: parent nucleotide sequence, 4x4 substitution-probability matrix and two child IDs.
- Samples a child sequence site-by-site, LANES sites per cycle, using per-lane LFSR random draws against the matrix row chosen by each parent nucleotide.
- Leaf packets (both child IDs zero) pass straight through. Input and output use valid/ready handshakes.

---
 rtl/pe_evolve_pkg.sv | 36 +++
 rtl/pe_evolve_par_rg_lane.sv | 69 ++++++
 rtl/pe_evolve_par.sv | 161 ++++++++++++++++
 tb/tb_pe_evolve_par.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_evolve_pkg.sv
// Shared types, defaults and slicing helpers for the evolution processing element.
package pe_evolve_pkg;

    typedef enum logic [1:0] {
        NUC_A = 2'b00,
        NUC_C = 2'b01,
        NUC_G = 2'b10,
        NUC_T = 2'b11
    } nuc_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_SAMPLE = 2'b01,
        ST_OUT    = 2'b10
    } state_e;

    localparam logic [15:0] LFSR_POLY_DEF = 16'hB400;
    localparam logic [15:0] LFSR_SEED_DEF = 16'hACE1;

    // Helpers work on the widest supported packet; callers zero-extend and truncate.
    localparam int MAX_PROB_W   = 16;
    localparam int MAX_SITES    = 64;
    localparam int MATRIX_MAX_W = 16 * MAX_PROB_W;
    localparam int ROW_MAX_W    = 4 * MAX_PROB_W;
    localparam int SEQ_MAX_W    = 2 * MAX_SITES;

    function automatic logic [ROW_MAX_W-1:0] row_slice(input logic [MATRIX_MAX_W-1:0] matrix,
                                                       input logic [1:0] n, input int prob_w);
        return ROW_MAX_W'(matrix >> (int'(n) * 4 * prob_w));
    endfunction

    function automatic logic [1:0] site_slice(input logic [SEQ_MAX_W-1:0] seq, input int s);
        return 2'(seq >> (2 * s));
    endfunction

endpackage

// File: rtl/pe_evolve_par_rg_lane.sv
// One sampling lane: owns a Galois LFSR and turns a draw plus a matrix row
// into a sampled nucleotide by cumulative first-match comparison.
module rg_lane
    import pe_evolve_pkg::*;
#(
    parameter int                PROB_W    = 10,
    parameter int                LFSR_W    = 16,
    parameter logic [LFSR_W-1:0] LFSR_POLY = LFSR_W'(LFSR_POLY_DEF),
    parameter logic [LFSR_W-1:0] LFSR_SEED = LFSR_W'(LFSR_SEED_DEF),
    parameter int                LANE_IDX  = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic                 step,
    input  logic [7:0]           seed_id,
    input  logic [16*PROB_W-1:0] matrix,
    input  logic [1:0]           nuc,
    output logic [1:0]           result
);

    logic [LFSR_W-1:0]   lfsr_r;
    logic [LFSR_W-1:0]   mix_s;
    logic [3*PROB_W-1:0] probs_s;
    logic [PROB_W+1:0]   c_a_s;
    logic [PROB_W+1:0]   c_c_s;
    logic [PROB_W+1:0]   c_g_s;
    logic [PROB_W+1:0]   draw_s;
    logic [1:0]          result_s;

    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] v);
        return v[0] ? ((v >> 1) ^ LFSR_POLY) : (v >> 1);
    endfunction

    assign mix_s  = lfsr_r ^ LFSR_W'({seed_id, 8'(LANE_IDX)});
    assign result = result_s;

    // Row pick and cumulative compare; pT is implicit as the residual mass.
    always_comb begin
        probs_s = (3 * PROB_W)'(row_slice(MATRIX_MAX_W'(matrix), nuc, PROB_W) >> PROB_W);
        c_a_s   = {2'b00, probs_s[3*PROB_W-1:2*PROB_W]};
        c_c_s   = c_a_s + {2'b00, probs_s[2*PROB_W-1:PROB_W]};
        c_g_s   = c_c_s + {2'b00, probs_s[PROB_W-1:0]};
        draw_s  = {2'b00, lfsr_r[PROB_W-1:0]};
        if (draw_s < c_a_s) begin
            result_s = NUC_A;
        end else if (draw_s < c_c_s) begin
            result_s = NUC_C;
        end else if (draw_s < c_g_s) begin
            result_s = NUC_G;
        end else begin
            result_s = NUC_T;
        end
    end

    // LFSR: reseeded on accept (never to zero), stepped once per sampling beat.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lfsr_r <= LFSR_SEED ^ LFSR_W'(LANE_IDX);
        end else if (load) begin
            lfsr_r <= (mix_s == {LFSR_W{1'b0}}) ? LFSR_W'(1) : mix_s;
        end else if (step) begin
            lfsr_r <= lfsr_next(lfsr_r);
        end else begin
            lfsr_r <= lfsr_r;
        end
    end

endmodule

// File: rtl/pe_evolve_par.sv
// Evolution PE: samples a child sequence LANES sites per cycle from a parent
// packet and its substitution matrix; leaf packets pass straight through.
module pe_evolve_par
    import pe_evolve_pkg::*;
#(
    parameter int                NUM_SITES = 16,
    parameter int                LANES     = 4,
    parameter int                PROB_W    = 10,
    parameter int                CHILD_W   = 3,
    parameter int                LFSR_W    = 16,
    parameter logic [LFSR_W-1:0] LFSR_POLY = LFSR_W'(LFSR_POLY_DEF),
    parameter logic [LFSR_W-1:0] LFSR_SEED = LFSR_W'(LFSR_SEED_DEF)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [7:0]             seed_id,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [2*NUM_SITES-1:0] in_seq,
    input  logic [16*PROB_W-1:0]   in_matrix,
    input  logic [CHILD_W-1:0]     in_child_1,
    input  logic [CHILD_W-1:0]     in_child_2,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [2*NUM_SITES-1:0] out_seq,
    output logic [CHILD_W-1:0]     out_child_1,
    output logic [CHILD_W-1:0]     out_child_2,
    output logic                   out_leaf,
    output logic                   busy
);

    localparam int NUM_BEATS = NUM_SITES / LANES;
    localparam int BEAT_W    = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
    localparam int SEQ_W     = 2 * NUM_SITES;
    localparam int MAT_W     = 16 * PROB_W;

    state_e             state_r;
    logic [BEAT_W-1:0]  beat_r;
    logic [SEQ_W-1:0]   seq_cap_r;
    logic [MAT_W-1:0]   matrix_cap_r;
    logic [SEQ_W-1:0]   out_seq_r;
    logic [SEQ_W-1:0]   seq_next_s;
    logic [CHILD_W-1:0] child_1_r;
    logic [CHILD_W-1:0] child_2_r;
    logic               out_leaf_r;
    logic               out_valid_r;
    logic               in_ready_r;
    logic               busy_r;
    logic               accept_s;
    logic               step_s;
    logic               leaf_s;
    logic               last_beat_s;
    logic [1:0]         lane_nuc_s [LANES];
    logic [1:0]         lane_res_s [LANES];

    assign accept_s    = in_valid && in_ready_r;
    assign step_s      = (state_r == ST_SAMPLE);
    assign leaf_s      = (in_child_1 == {CHILD_W{1'b0}}) && (in_child_2 == {CHILD_W{1'b0}});
    assign last_beat_s = (beat_r == BEAT_W'(NUM_BEATS - 1));

    assign in_ready    = in_ready_r;
    assign out_valid   = out_valid_r;
    assign out_seq     = out_seq_r;
    assign out_child_1 = child_1_r;
    assign out_child_2 = child_2_r;
    assign out_leaf    = out_leaf_r;
    assign busy        = busy_r;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        assign lane_nuc_s[g] = site_slice(SEQ_MAX_W'(seq_cap_r), int'(beat_r) * LANES + g);

        rg_lane #(
            .PROB_W   (PROB_W),
            .LFSR_W   (LFSR_W),
            .LFSR_POLY(LFSR_POLY),
            .LFSR_SEED(LFSR_SEED),
            .LANE_IDX (g)
        ) u_lane (
            .clk    (clk),
            .reset  (reset),
            .load   (accept_s),
            .step   (step_s),
            .seed_id(seed_id),
            .matrix (matrix_cap_r),
            .nuc    (lane_nuc_s[g]),
            .result (lane_res_s[g])
        );
    end

    // Merge this beat's lane results into their site slots.
    always_comb begin
        seq_next_s = out_seq_r;
        for (int i = 0; i < LANES; i++) begin
            seq_next_s[2*(int'(beat_r) * LANES + i) +: 2] = lane_res_s[i];
        end
    end

    // Packet FSM with registered handshake and status outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r      <= ST_IDLE;
            beat_r       <= {BEAT_W{1'b0}};
            seq_cap_r    <= {SEQ_W{1'b0}};
            matrix_cap_r <= {MAT_W{1'b0}};
            out_seq_r    <= {SEQ_W{1'b0}};
            child_1_r    <= {CHILD_W{1'b0}};
            child_2_r    <= {CHILD_W{1'b0}};
            out_leaf_r   <= 1'b0;
            out_valid_r  <= 1'b0;
            in_ready_r   <= 1'b1;
            busy_r       <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        seq_cap_r    <= in_seq;
                        matrix_cap_r <= in_matrix;
                        child_1_r    <= in_child_1;
                        child_2_r    <= in_child_2;
                        in_ready_r   <= 1'b0;
                        busy_r       <= 1'b1;
                        if (leaf_s) begin
                            out_seq_r   <= in_seq;
                            out_leaf_r  <= 1'b1;
                            out_valid_r <= 1'b1;
                            state_r     <= ST_OUT;
                        end else begin
                            beat_r     <= {BEAT_W{1'b0}};
                            out_leaf_r <= 1'b0;
                            state_r    <= ST_SAMPLE;
                        end
                    end
                end
                ST_SAMPLE: begin
                    out_seq_r <= seq_next_s;
                    if (last_beat_s) begin
                        out_valid_r <= 1'b1;
                        state_r     <= ST_OUT;
                    end else begin
                        beat_r <= beat_r + BEAT_W'(1);
                    end
                end
                ST_OUT: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        busy_r      <= 1'b0;
                        state_r     <= ST_IDLE;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                    busy_r      <= 1'b0;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pe_evolve_par.sv
// Randomised bench for pe_evolve_par: four parameterisations checked against a
// site-by-site probability-sampling model with per-lane LFSR draws.
`timescale 1ns/1ps
module tb_pe_evolve_par;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [3:0]         in_valid_v;
    logic [3:0]         out_ready_v;
    logic [3:0][63:0]   in_seq_v;
    logic [3:0][191:0]  in_mat_v;
    logic [3:0][2:0]    in_c1_v;
    logic [3:0][2:0]    in_c2_v;
    logic [3:0][7:0]    seed_v;
    wire  [3:0]         in_ready_v;
    wire  [3:0]         out_valid_v;
    wire  [3:0]         out_leaf_v;
    wire  [3:0]         busy_v;
    wire  [3:0][2:0]    out_c1_v;
    wire  [3:0][2:0]    out_c2_v;
    wire  [31:0]        seq0, seq1, seq2;
    wire  [63:0]        seq3;
    logic [63:0]        out_seq_v [4];

    always_comb begin
        out_seq_v[0] = {32'd0, seq0};
        out_seq_v[1] = {32'd0, seq1};
        out_seq_v[2] = {32'd0, seq2};
        out_seq_v[3] = seq3;
    end

    pe_evolve_par #(.NUM_SITES(16), .LANES(4), .PROB_W(10)) u_dut0 (
        .clk(clk), .reset(reset), .seed_id(seed_v[0]), .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
        .in_seq(in_seq_v[0][31:0]), .in_matrix(in_mat_v[0][159:0]), .in_child_1(in_c1_v[0]), .in_child_2(in_c2_v[0]),
        .out_valid(out_valid_v[0]), .out_ready(out_ready_v[0]), .out_seq(seq0), .out_child_1(out_c1_v[0]),
        .out_child_2(out_c2_v[0]), .out_leaf(out_leaf_v[0]), .busy(busy_v[0]));

    pe_evolve_par #(.NUM_SITES(16), .LANES(1), .PROB_W(10)) u_dut1 (
        .clk(clk), .reset(reset), .seed_id(seed_v[1]), .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
        .in_seq(in_seq_v[1][31:0]), .in_matrix(in_mat_v[1][159:0]), .in_child_1(in_c1_v[1]), .in_child_2(in_c2_v[1]),
        .out_valid(out_valid_v[1]), .out_ready(out_ready_v[1]), .out_seq(seq1), .out_child_1(out_c1_v[1]),
        .out_child_2(out_c2_v[1]), .out_leaf(out_leaf_v[1]), .busy(busy_v[1]));

    pe_evolve_par #(.NUM_SITES(16), .LANES(16), .PROB_W(10)) u_dut2 (
        .clk(clk), .reset(reset), .seed_id(seed_v[2]), .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]),
        .in_seq(in_seq_v[2][31:0]), .in_matrix(in_mat_v[2][159:0]), .in_child_1(in_c1_v[2]), .in_child_2(in_c2_v[2]),
        .out_valid(out_valid_v[2]), .out_ready(out_ready_v[2]), .out_seq(seq2), .out_child_1(out_c1_v[2]),
        .out_child_2(out_c2_v[2]), .out_leaf(out_leaf_v[2]), .busy(busy_v[2]));

    pe_evolve_par #(.NUM_SITES(32), .LANES(4), .PROB_W(12)) u_dut3 (
        .clk(clk), .reset(reset), .seed_id(seed_v[3]), .in_valid(in_valid_v[3]), .in_ready(in_ready_v[3]),
        .in_seq(in_seq_v[3]), .in_matrix(in_mat_v[3]), .in_child_1(in_c1_v[3]), .in_child_2(in_c2_v[3]),
        .out_valid(out_valid_v[3]), .out_ready(out_ready_v[3]), .out_seq(seq3), .out_child_1(out_c1_v[3]),
        .out_child_2(out_c2_v[3]), .out_leaf(out_leaf_v[3]), .busy(busy_v[3]));

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int ns_of(input int d);
        return (d == 3) ? 32 : 16;
    endfunction

    function automatic int ln_of(input int d);
        case (d)
            1:       return 1;
            2:       return 16;
            default: return 4;
        endcase
    endfunction

    function automatic int pw_of(input int d);
        return (d == 3) ? 12 : 10;
    endfunction

    // Reference model: per-DUT, per-lane LFSR state.
    logic [15:0] mlfsr [4][16];

    function automatic logic [15:0] galois(input logic [15:0] v);
        return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
    endfunction

    function automatic int prob(input logic [191:0] m, input int off, input int pw);
        return int'((m >> off) & ((192'd1 << pw) - 192'd1));
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 4; d++)
            for (int i = 0; i < 16; i++)
                mlfsr[d][i] = 16'hACE1 ^ 16'(i);
    endtask

    task automatic model_pkt(input int d, input logic [63:0] seq, input logic [191:0] mat,
                             input logic [2:0] c1, input logic [2:0] c2, input logic [7:0] sid,
                             output logic [63:0] exp_seq, output logic exp_leaf);
        int ns, ln, pw, lane, r, n, base, ca, cc, cg, nucv;
        logic [15:0] v;
        logic [63:0] smask;
        ns = ns_of(d); ln = ln_of(d); pw = pw_of(d);
        smask = (64'd1 << (2 * ns)) - 64'd1;
        for (int i = 0; i < ln; i++) begin
            v = mlfsr[d][i] ^ {sid, 8'(i)};
            mlfsr[d][i] = (v == 16'd0) ? 16'd1 : v;
        end
        exp_leaf = (c1 == 3'd0) && (c2 == 3'd0);
        exp_seq  = 64'd0;
        if (exp_leaf) begin
            exp_seq = seq & smask;
        end else begin
            for (int s = 0; s < ns; s++) begin
                lane = s % ln;
                r    = int'(mlfsr[d][lane]) % (1 << pw);
                n    = int'((seq >> (2 * s)) & 64'd3);
                base = n * 4 * pw;
                ca   = prob(mat, base + 3 * pw, pw);
                cc   = ca + prob(mat, base + 2 * pw, pw);
                cg   = cc + prob(mat, base + pw, pw);
                if (r < ca)      nucv = 0;
                else if (r < cc) nucv = 1;
                else if (r < cg) nucv = 2;
                else             nucv = 3;
                exp_seq |= 64'(nucv) << (2 * s);
                mlfsr[d][lane] = galois(mlfsr[d][lane]);
            end
        end
    endtask

    function automatic logic [191:0] rand_mat(input int pw);
        logic [191:0] m = 192'd0;
        for (int f = 0; f < 16; f++)
            m |= 192'($urandom_range(0, (1 << pw) - 1)) << (f * pw);
        return m;
    endfunction

    function automatic logic [191:0] mk_row(input int n, input int pa, input int pc, input int pg,
                                            input int pt, input int pw);
        return ((192'(pa) << (3 * pw)) | (192'(pc) << (2 * pw)) | (192'(pg) << pw) | 192'(pt))
               << (n * 4 * pw);
    endfunction

    task automatic do_reset();
        reset = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    // One packet: accept, latency, payload, optional backpressure, release.
    task automatic run_pkt(input int d, input logic [63:0] seq, input logic [191:0] mat,
                           input logic [2:0] c1, input logic [2:0] c2, input logic [7:0] sid,
                           input int hold, input string tag,
                           output logic [63:0] exp_seq, output logic [63:0] got);
        logic exp_leaf;
        int lat, guard, exp_lat;
        guard = 0;
        while (in_ready_v[d] !== 1'b1 && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        check_eq({tag, "_idle"}, 64'(in_ready_v[d]), 64'd1);
        in_valid_v[d] = 1'b1; in_seq_v[d] = seq; in_mat_v[d] = mat;
        in_c1_v[d] = c1; in_c2_v[d] = c2; seed_v[d] = sid;
        model_pkt(d, seq, mat, c1, c2, sid, exp_seq, exp_leaf);
        exp_lat = exp_leaf ? 1 : ns_of(d) / ln_of(d) + 1;
        lat = 0;
        do begin
            @(negedge clk);
            in_valid_v[d] = 1'b0;
            lat++;
        end while (out_valid_v[d] !== 1'b1 && lat < 40);
        got = out_seq_v[d];
        check_eq({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        check_eq({tag, "_seq"}, got, exp_seq);
        check_eq({tag, "_leaf"}, 64'(out_leaf_v[d]), 64'(exp_leaf));
        check_eq({tag, "_c1"}, 64'(out_c1_v[d]), 64'(c1));
        check_eq({tag, "_c2"}, 64'(out_c2_v[d]), 64'(c2));
        for (int h = 0; h < hold; h++) begin
            in_valid_v[d] = h[0];
            in_seq_v[d]   = {$urandom, $urandom};
            in_c1_v[d]    = 3'($urandom_range(1, 7));
            @(negedge clk);
            check_eq({tag, "_hold_v"}, 64'(out_valid_v[d]), 64'd1);
            check_eq({tag, "_hold_seq"}, out_seq_v[d], exp_seq);
            check_eq({tag, "_hold_c1"}, 64'(out_c1_v[d]), 64'(c1));
            check_eq({tag, "_hold_c2"}, 64'(out_c2_v[d]), 64'(c2));
            check_eq({tag, "_hold_rdy"}, 64'(in_ready_v[d]), 64'd0);
        end
        in_valid_v[d]  = 1'b0;
        out_ready_v[d] = 1'b1;
        @(negedge clk);
        out_ready_v[d] = 1'b0;
        check_eq({tag, "_drop_v"}, 64'(out_valid_v[d]), 64'd0);
        check_eq({tag, "_back_rdy"}, 64'(in_ready_v[d]), 64'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] e, g, e1, g2, pseq;
        logic [191:0] m, pmat;
        logic [2:0] c1, c2;
        in_valid_v = 4'd0; out_ready_v = 4'd0; in_seq_v = '0; in_mat_v = '0;
        in_c1_v = '0; in_c2_v = '0; seed_v = '0;
        do_reset();

        check_eq("rst_out_valid", 64'(out_valid_v[0]), 64'd0);
        check_eq("rst_in_ready", 64'(in_ready_v[0]), 64'd1);
        check_eq("rst_busy", 64'(busy_v[0]), 64'd0);
        check_eq("rst_out_seq", out_seq_v[0], 64'd0);
        check_eq("rst_leaf", 64'(out_leaf_v[0]), 64'd0);
        check_eq("rst_child", 64'({out_c1_v[0], out_c2_v[0]}), 64'd0);

        run_pkt(0, 64'h1234_5678, rand_mat(10), 3'd0, 3'd0, 8'h11, 0, "leaf", e, g);
        check_eq("leaf_literal", g, 64'h1234_5678);

        run_pkt(0, 64'd0, 192'd0, 3'd3, 3'd4, 8'h22, 0, "zero_mat", e, g);
        check_eq("zero_mat_allT", g, 64'hFFFF_FFFF);

        m = mk_row(1, 1023, 1, 0, 0, 10) | mk_row(2, 1023, 1, 0, 0, 10) | mk_row(3, 1023, 1, 0, 0, 10);
        run_pkt(0, 64'd0, m, 3'd1, 3'd2, 8'h5A, 0, "row_allA", e, g);
        check_eq("row_allA_T", g, 64'hFFFF_FFFF);
        run_pkt(0, 64'h5555_5555, m, 3'd1, 3'd2, 8'h5A, 0, "row_allC", e, g);

        run_pkt(0, {32'd0, $urandom}, rand_mat(10), 3'd5, 3'd6, 8'h77, 10, "bp", e, g);
        run_pkt(0, {32'd0, $urandom}, rand_mat(10), 3'd2, 3'd0, 8'h78, 0, "bp_next", e, g);

        for (int k = 0; k < 30; k++) begin
            c1 = 3'($urandom_range(0, 7));
            c2 = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 4) == 0) begin
                c1 = 3'd0;
                c2 = 3'd0;
            end
            run_pkt(0, {32'd0, $urandom}, rand_mat(10), c1, c2, 8'($urandom), 0, "rnd16", e, g);
        end

        pseq = {32'd0, $urandom};
        pmat = rand_mat(10);
        do_reset();
        run_pkt(0, pseq, pmat, 3'd2, 3'd5, 8'h33, 0, "fresh", e1, g);
        do_reset();
        in_valid_v[0] = 1'b1; in_seq_v[0] = pseq; in_mat_v[0] = pmat;
        in_c1_v[0] = 3'd2; in_c2_v[0] = 3'd5; seed_v[0] = 8'h33;
        repeat (3) begin
            @(negedge clk);
            in_valid_v[0] = 1'b0;
        end
        check_eq("mid_busy", 64'(busy_v[0]), 64'd1);
        reset = 1'b0;
        #1;
        check_eq("abort_out_valid", 64'(out_valid_v[0]), 64'd0);
        check_eq("abort_in_ready", 64'(in_ready_v[0]), 64'd1);
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        run_pkt(0, pseq, pmat, 3'd2, 3'd5, 8'h33, 0, "replay", e, g2);
        check_eq("replay_vs_fresh", g2, e1);

        for (int k = 0; k < 3; k++) begin
            run_pkt(1, {32'd0, $urandom}, rand_mat(10), 3'd1, 3'd7, 8'($urandom), 0, "lanes1", e, g);
            run_pkt(2, {32'd0, $urandom}, rand_mat(10), 3'd4, 3'd3, 8'($urandom), 0, "lanes16", e, g);
        end

        for (int k = 0; k < 100; k++) begin
            c1 = 3'($urandom_range(0, 7));
            c2 = 3'($urandom_range(0, 7));
            run_pkt(3, {$urandom, $urandom}, rand_mat(12), c1, c2, 8'($urandom), 0, "w32", e, g);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
